// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i core memory path.
//   mem_funct3_e     : funct3 width/sign codes for loads (store codes alias them)
//   memstage_state_e : memstage FSM states
package rv32i_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd4,
    LHU = 3'd5
  } mem_funct3_e;

  // Store codes share encodings with the signed loads, and an enum cannot
  // hold duplicate values, so they are typed aliases.
  localparam mem_funct3_e SB = LB;
  localparam mem_funct3_e SH = LH;
  localparam mem_funct3_e SW = LW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } memstage_state_e;

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic for memstage.
//   Store side : offset, funct3, is_load/is_store, store_data
//                -> be, wdata, bad_access (misaligned or illegal funct3)
//   Load side  : ld_offset, ld_funct3, rdata -> ld_data (shifted, extended)
module mem_align
  import rv32i_pkg::*;
(
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        bad_access,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [31:0] sh;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    be         = 4'b0000;
    wdata      = 32'h0;
    bad_access = 1'b0;
    if (is_store) begin
      case (funct3)
        SB: begin
          be    = 4'b0001 << offset;
          wdata = {4{store_data[7:0]}};
        end
        SH: begin
          be         = 4'b0011 << offset;
          wdata      = {2{store_data[15:0]}};
          bad_access = offset[0];
        end
        SW: begin
          be         = 4'b1111;
          wdata      = store_data;
          bad_access = |offset;
        end
        default: bad_access = 1'b1;
      endcase
    end else if (is_load) begin
      be = 4'b1111;
      case (funct3)
        LB, LBU: bad_access = 1'b0;
        LH, LHU: bad_access = offset[0];
        LW:      bad_access = |offset;
        default: bad_access = 1'b1;
      endcase
    end
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  assign sh = rdata >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = rdata;
    case (ld_funct3)
      LB:      ld_data = {{24{sh[7]}}, sh[7:0]};
      LBU:     ld_data = {24'h0, sh[7:0]};
      LH:      ld_data = {{16{sh[15]}}, sh[15:0]};
      LHU:     ld_data = {16'h0, sh[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule

// File: rtl/memstage.sv
// Memory-access stage of the rv32i core (between exstage and wbstage).
//   ex_*   : instruction from exstage, valid/ready handshake
//   dmem_* : req/gnt/rvalid data-memory bus, one transaction in flight
//   wb_*   : one registered result per instruction, valid/ready to wbstage
//   exc_misaligned_o : one-cycle pulse on misaligned access or illegal funct3
module memstage
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic [XLEN-1:0] ex_alu_result_i,
  input  logic [XLEN-1:0] ex_store_data_i,
  input  logic            ex_is_load_i,
  input  logic            ex_is_store_i,
  input  logic [2:0]      ex_funct3_i,
  input  logic [4:0]      ex_rd_i,
  input  logic            ex_reg_write_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            exc_misaligned_o
);

  memstage_state_e state;

  // Context of the load/store in flight.
  logic [2:0] funct3_q;
  logic [1:0] offset_q;
  logic [4:0] rd_q;
  logic       reg_write_q;

  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        bad_access;
  logic [31:0] ld_data;
  logic        accept;
  logic        is_mem;

  mem_align u_align (
    .is_load    (ex_is_load_i),
    .is_store   (ex_is_store_i),
    .funct3     (ex_funct3_i),
    .offset     (ex_alu_result_i[1:0]),
    .store_data (ex_store_data_i),
    .be         (st_be),
    .wdata      (st_wdata),
    .bad_access (bad_access),
    .ld_funct3  (funct3_q),
    .ld_offset  (offset_q),
    .rdata      (dmem_rdata_i),
    .ld_data    (ld_data)
  );

  // A new instruction may enter in the same cycle wbstage drains the
  // current result, giving 1/cycle throughput for non-memory ops.
  assign ex_ready_o = (state == IDLE) && (!wb_valid_o || wb_ready_i);
  assign accept     = ex_valid_i && ex_ready_o;
  assign is_mem     = ex_is_load_i || ex_is_store_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      // Clearing dmem_req_o here abandons any transaction; a late rvalid
      // then lands in IDLE where it is ignored.
      state            <= IDLE;
      dmem_req_o       <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_be_o        <= 4'b0000;
      dmem_wdata_o     <= '0;
      funct3_q         <= 3'd0;
      offset_q         <= 2'd0;
      rd_q             <= 5'd0;
      reg_write_q      <= 1'b0;
      wb_valid_o       <= 1'b0;
      wb_rd_o          <= 5'd0;
      wb_reg_write_o   <= 1'b0;
      wb_data_o        <= '0;
      exc_misaligned_o <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; a later assignment in
      // this block overrides the earlier defaults within the same cycle.
      exc_misaligned_o <= 1'b0;
      if (wb_valid_o && wb_ready_i) wb_valid_o <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            if (!is_mem) begin
              wb_valid_o     <= 1'b1;
              wb_rd_o        <= ex_rd_i;
              wb_reg_write_o <= ex_reg_write_i;
              wb_data_o      <= ex_alu_result_i;
            end else if (bad_access) begin
              // Retire as a no-op and flag the exception.
              wb_valid_o       <= 1'b1;
              wb_rd_o          <= ex_rd_i;
              wb_reg_write_o   <= 1'b0;
              wb_data_o        <= '0;
              exc_misaligned_o <= 1'b1;
            end else begin
              state        <= REQ;
              dmem_req_o   <= 1'b1;
              dmem_we_o    <= ex_is_store_i;
              dmem_addr_o  <= {ex_alu_result_i[XLEN-1:2], 2'b00};
              dmem_be_o    <= st_be;
              dmem_wdata_o <= st_wdata;
              funct3_q     <= ex_funct3_i;
              offset_q     <= ex_alu_result_i[1:0];
              rd_q         <= ex_rd_i;
              reg_write_q  <= ex_reg_write_i;
            end
          end
        end

        REQ: begin
          // Request fields stay frozen until the memory grants.
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              state          <= IDLE;
              wb_valid_o     <= 1'b1;
              wb_rd_o        <= rd_q;
              wb_reg_write_o <= 1'b0;
              wb_data_o      <= '0;
            end else begin
              state <= RESP;
            end
          end
        end

        RESP: begin
          if (dmem_rvalid_i) begin
            state          <= IDLE;
            wb_valid_o     <= 1'b1;
            wb_rd_o        <= rd_q;
            wb_reg_write_o <= reg_write_q;
            wb_data_o      <= ld_data;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memstage.sv
module tb_memstage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [31:0] ex_alu_result_i;
  logic [31:0] ex_store_data_i;
  logic        ex_is_load_i;
  logic        ex_is_store_i;
  logic [2:0]  ex_funct3_i;
  logic [4:0]  ex_rd_i;
  logic        ex_reg_write_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [31:0] dmem_addr_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic [31:0] wb_data_o;
  logic        exc_misaligned_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  memstage #(.XLEN(32)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .ex_alu_result_i  (ex_alu_result_i),
    .ex_store_data_i  (ex_store_data_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_is_store_i    (ex_is_store_i),
    .ex_funct3_i      (ex_funct3_i),
    .ex_rd_i          (ex_rd_i),
    .ex_reg_write_i   (ex_reg_write_i),
    .dmem_req_o       (dmem_req_o),
    .dmem_we_o        (dmem_we_o),
    .dmem_addr_o      (dmem_addr_o),
    .dmem_be_o        (dmem_be_o),
    .dmem_wdata_o     (dmem_wdata_o),
    .dmem_gnt_i       (dmem_gnt_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .wb_valid_o       (wb_valid_o),
    .wb_ready_i       (wb_ready_i),
    .wb_rd_o          (wb_rd_o),
    .wb_reg_write_o   (wb_reg_write_o),
    .wb_data_o        (wb_data_o),
    .exc_misaligned_o (exc_misaligned_o)
  );

  // Advance one clock; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata,
                       input logic [4:0] rd, input logic rw);
    ex_valid_i      = 1'b1;
    ex_is_load_i    = ld;
    ex_is_store_i   = st;
    ex_funct3_i     = f3;
    ex_alu_result_i = addr;
    ex_store_data_i = sdata;
    ex_rd_i         = rd;
    ex_reg_write_i  = rw;
  endtask

  task automatic idle_ex();
    ex_valid_i    = 1'b0;
    ex_is_load_i  = 1'b0;
    ex_is_store_i = 1'b0;
  endtask

  // Load with immediate gnt and rvalid two cycles later; returns wb outputs.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rdata,
                          output logic valid, output logic [31:0] data);
    drive(1'b1, 1'b0, f3, addr, 32'h0, 5'd9, 1'b1);
    tick();
    idle_ex();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    tick();
    dmem_rvalid_i = 1'b0;
    valid = wb_valid_o;
    data  = wb_data_o;
    tick();
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0 || exc_misaligned_o !== 1'b0 ||
        wb_data_o !== 32'h0 || dmem_addr_o !== 32'h0 || wb_rd_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: req=%b wb_valid=%b exc=%b wb_data=%h addr=%h rd=%0d, expected all 0",
               dmem_req_o, wb_valid_o, exc_misaligned_o, wb_data_o, dmem_addr_o, wb_rd_o);
    end
    n_checks++;
    if (ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", ex_ready_o);
    end
  endtask

  task automatic test_nonmem();
    logic req_seen;
    drive(1'b0, 1'b0, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    tick();
    idle_ex();
    req_seen = dmem_req_o;
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_1234 || wb_rd_o !== 5'd5 ||
        wb_reg_write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL nonmem_result: valid=%b data=%h rd=%0d rw=%b expected 1 00001234 5 1",
               wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o);
    end
    tick();
    req_seen = req_seen | dmem_req_o;
    n_checks++;
    if (req_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem_no_req: got %b expected 0", req_seen);
    end
    n_checks++;
    if (wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL nonmem_consumed: wb_valid got %b expected 0", wb_valid_o);
    end
  endtask

  task automatic test_store();
    drive(1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 1'b0);
    tick();
    idle_ex();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dmem_gnt_i = 1'b1;
      n_checks++;
      if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1 || dmem_addr_o !== 32'h0000_1000 ||
          dmem_be_o !== 4'b1000 || dmem_wdata_o !== 32'hDDDD_DDDD || ex_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL sb_req_cycle%0d: req=%b we=%b addr=%h be=%b wdata=%h rdy=%b expected 1 1 00001000 1000 dddddddd 0",
                 i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o, ex_ready_o);
      end
      tick();
    end
    dmem_gnt_i = 1'b0;
    n_checks++;
    if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_retire: req=%b wb_valid=%b rw=%b expected 0 1 0",
               dmem_req_o, wb_valid_o, wb_reg_write_o);
    end
    tick();

    // SH at offset 2 and SW, granted immediately.
    drive(1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'h1234_ABCD, 5'd0, 1'b0);
    tick();
    idle_ex();
    dmem_gnt_i = 1'b1;
    n_checks++;
    if (dmem_addr_o !== 32'h0000_1000 || dmem_be_o !== 4'b1100 || dmem_wdata_o !== 32'hABCD_ABCD) begin
      n_fail++;
      $display("FAIL sh_lanes: addr=%h be=%b wdata=%h expected 00001000 1100 abcdabcd",
               dmem_addr_o, dmem_be_o, dmem_wdata_o);
    end
    tick();
    dmem_gnt_i = 1'b0;
    tick();
    drive(1'b0, 1'b1, 3'd2, 32'h0000_1004, 32'h1234_ABCD, 5'd0, 1'b0);
    tick();
    idle_ex();
    dmem_gnt_i = 1'b1;
    n_checks++;
    if (dmem_addr_o !== 32'h0000_1004 || dmem_be_o !== 4'b1111 || dmem_wdata_o !== 32'h1234_ABCD) begin
      n_fail++;
      $display("FAIL sw_lanes: addr=%h be=%b wdata=%h expected 00001004 1111 1234abcd",
               dmem_addr_o, dmem_be_o, dmem_wdata_o);
    end
    tick();
    dmem_gnt_i = 1'b0;
    tick();
  endtask

  task automatic test_loads();
    logic        v;
    logic [31:0] d;
    // Check the load request shape once.
    drive(1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'hFFFF_FFFF, 5'd9, 1'b1);
    tick();
    idle_ex();
    n_checks++;
    if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0 || dmem_be_o !== 4'b1111 ||
        dmem_addr_o !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL load_req: req=%b we=%b be=%b addr=%h expected 1 0 1111 00003000",
               dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o);
    end
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h1234_5678;
    tick();
    dmem_rvalid_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h1234_5678 || wb_rd_o !== 5'd9 ||
        wb_reg_write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_data: valid=%b data=%h rd=%0d rw=%b expected 1 12345678 9 1",
               wb_valid_o, wb_data_o, wb_rd_o, wb_reg_write_o);
    end
    tick();

    run_load(3'd0, 32'h0000_2002, 32'h0080_0000, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 32'hFFFF_FF80) begin
      n_fail++;
      $display("FAIL lb_sign: valid=%b data=%h expected 1 ffffff80", v, d);
    end
    run_load(3'd4, 32'h0000_2002, 32'h0080_0000, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL lbu_zero: valid=%b data=%h expected 1 00000080", v, d);
    end
    run_load(3'd1, 32'h0000_2002, 32'h8001_0000, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 32'hFFFF_8001) begin
      n_fail++;
      $display("FAIL lh_sign: valid=%b data=%h expected 1 ffff8001", v, d);
    end
    run_load(3'd5, 32'h0000_2002, 32'h8001_0000, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0000_8001) begin
      n_fail++;
      $display("FAIL lhu_zero: valid=%b data=%h expected 1 00008001", v, d);
    end
    run_load(3'd0, 32'h0000_2001, 32'h0000_7F00, v, d);
    n_checks++;
    if (v !== 1'b1 || d !== 32'h0000_007F) begin
      n_fail++;
      $display("FAIL lb_off1: valid=%b data=%h expected 1 0000007f", v, d);
    end
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3_tab   [3] = '{3'd2, 3'd3, 3'd1};
    logic [31:0] addr_tab [3] = '{32'h0000_3001, 32'h0000_3000, 32'h0000_3003};
    logic        st_tab   [3] = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(!st_tab[i], st_tab[i], f3_tab[i], addr_tab[i], 32'h5555_5555, 5'd4, 1'b1);
      tick();
      idle_ex();
      n_checks++;
      if (exc_misaligned_o !== 1'b1 || wb_valid_o !== 1'b1 || wb_reg_write_o !== 1'b0 ||
          wb_data_o !== 32'h0 || dmem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned%0d: exc=%b valid=%b rw=%b data=%h req=%b expected 1 1 0 0 0",
                 i, exc_misaligned_o, wb_valid_o, wb_reg_write_o, wb_data_o, dmem_req_o);
      end
      tick();
      n_checks++;
      if (exc_misaligned_o !== 1'b0 || dmem_req_o !== 1'b0) begin
        n_fail++;
        $display("FAIL misaligned%0d_pulse: exc=%b req=%b expected 0 0",
                 i, exc_misaligned_o, dmem_req_o);
      end
    end
  endtask

  task automatic test_wb_hold();
    wb_ready_i = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'h0000_CAFE, 32'h0, 5'd7, 1'b1);
    tick();
    drive(1'b0, 1'b0, 3'd0, 32'h0000_BEEF, 32'h0, 5'd8, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_CAFE || wb_rd_o !== 5'd7 ||
          ex_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL wb_hold%0d: valid=%b data=%h rd=%0d rdy=%b expected 1 0000cafe 7 0",
                 i, wb_valid_o, wb_data_o, wb_rd_o, ex_ready_o);
      end
      tick();
    end
    wb_ready_i = 1'b1;
    #1;
    n_checks++;
    if (ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL wb_release_ready: got %b expected 1", ex_ready_o);
    end
    tick();
    idle_ex();
    n_checks++;
    if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_BEEF || wb_rd_o !== 5'd8) begin
      n_fail++;
      $display("FAIL wb_release_next: valid=%b data=%h rd=%0d expected 1 0000beef 8",
               wb_valid_o, wb_data_o, wb_rd_o);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    // Reset while waiting for gnt.
    drive(1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'h0, 5'd3, 1'b1);
    tick();
    idle_ex();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_req: req=%b rdy=%b expected 0 1", dmem_req_o, ex_ready_o);
    end
    // Reset while waiting for rvalid, then a late rvalid.
    drive(1'b1, 1'b0, 3'd2, 32'h0000_4000, 32'h0, 5'd3, 1'b1);
    tick();
    idle_ex();
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || wb_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_resp: req=%b wb_valid=%b expected 0 0", dmem_req_o, wb_valid_o);
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'hDEAD_BEEF;
    tick();
    dmem_rvalid_i = 1'b0;
    n_checks++;
    if (wb_valid_o !== 1'b0 || wb_data_o !== 32'h0 || ex_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL late_rvalid: wb_valid=%b data=%h rdy=%b expected 0 00000000 1",
               wb_valid_o, wb_data_o, ex_ready_o);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    wb_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 3'd0, 32'h0000_0100 + i, 32'h0, 5'(i + 1), 1'b1);
      n_checks++;
      if (ex_ready_o !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_ready%0d: got %b expected 1", i, ex_ready_o);
      end
      tick();
      n_checks++;
      if (wb_valid_o !== 1'b1 || wb_data_o !== 32'h0000_0100 + i || wb_rd_o !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_result%0d: valid=%b data=%h rd=%0d expected 1 %h %0d",
                 i, wb_valid_o, wb_data_o, wb_rd_o, 32'h0000_0100 + i, i + 1);
      end
    end
    idle_ex();
    tick();
  endtask

  initial begin
    rst_i           = 1'b0;
    idle_ex();
    ex_funct3_i     = 3'd0;
    ex_alu_result_i = 32'h0;
    ex_store_data_i = 32'h0;
    ex_rd_i         = 5'd0;
    ex_reg_write_i  = 1'b0;
    dmem_gnt_i      = 1'b0;
    dmem_rvalid_i   = 1'b0;
    dmem_rdata_i    = 32'h0;
    wb_ready_i      = 1'b1;

    test_reset();
    test_nonmem();
    test_store();
    test_loads();
    test_misaligned();
    test_wb_hold();
    test_reset_midflight();
    test_back_to_back();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memstage.md
Name: memstage

Overview:
- Memory-access stage between exstage and wbstage of the rv32i core.
- Takes the ALU result (effective address or plain result), performs byte/half/word loads and stores over a req/gnt/rvalid data-memory bus, and hands one registered result per instruction to writeback.
- Only one memory transaction is in flight at a time; it stalls upstream via valid/ready.

Parameters:
- XLEN, 32, datapath and address width; only 32 is supported.

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous reset, active-low
- ex_valid_i  in  1  exstage presents an instruction
- ex_ready_o  out  1  memstage accepts this cycle
- ex_alu_result_i  in  32  effective address (load/store) or result (others)
- ex_store_data_i  in  32  rs2 value for stores
- ex_is_load_i  in  1  instruction is a load
- ex_is_store_i  in  1  instruction is a store
- ex_funct3_i  in  3  memory width/sign code
- ex_rd_i  in  5  destination register
- ex_reg_write_i  in  1  instruction writes rd
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-replicated store data
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  read data valid
- dmem_rdata_i  in  32  read data
- wb_valid_o  out  1  result available to wbstage
- wb_ready_i  in  1  wbstage consumes
- wb_rd_o  out  5  destination register
- wb_reg_write_o  out  1  write rd
- wb_data_o  out  32  result / extended load data
- exc_misaligned_o  out  1  one-cycle pulse: misaligned access or illegal funct3

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - FSM goes to IDLE; every output is 0 except ex_ready_o, which is 1 from the first cycle after reset.
  - A transaction in progress is abandoned; dmem_req_o is low the next cycle.
  - An rvalid arriving after reset is ignored.
- FSM states: IDLE, REQ, RESP.
- Acceptance:
  - ex_ready_o = (state==IDLE) && (!wb_valid_o || wb_ready_i).
  - An instruction is taken when ex_valid_i && ex_ready_o.
- Non-memory instruction: registered on accept and presented next cycle with wb_data_o = alu_result. Latency 1; state stays IDLE.
- Alignment check on accept:
  - half: addr[0]=1 is misaligned; word: addr[1:0]!=0 is misaligned.
  - Loads with funct3 in {3,6,7} or stores with funct3 >= 3 are illegal.
  - On a misaligned or illegal access: no memory request; exc_misaligned_o pulses the next cycle; the instruction retires with wb_valid_o=1, wb_reg_write_o=0, wb_data_o=0.
- Legal memory access: go to REQ.
  - dmem_req_o=1; addr, we, be and wdata are held stable until dmem_gnt_i.
  - Store on gnt: return to IDLE; wb_valid_o=1 next cycle with wb_reg_write_o=0.
  - Load on gnt: go to RESP. dmem_rvalid_i is legal no earlier than the cycle after gnt.
  - Load in RESP on rvalid: extract, extend and register the data; wb_valid_o=1 next cycle; return to IDLE.
- Store lanes (o = addr[1:0]):
  - SB: be = 4'b0001<<o, wdata = {4{data[7:0]}}.
  - SH: be = 4'b0011<<o, wdata = {2{data[15:0]}}.
  - SW: be = 4'b1111.
  - Loads drive be = 4'b1111, we = 0.
- Load extraction: sh = rdata >> (8*o).
  - LB: sign-extend sh[7:0]; LBU: zero-extend sh[7:0].
  - LH: sign-extend sh[15:0]; LHU: zero-extend sh[15:0].
  - LW: rdata.
- Writeback hold: while wb_valid_o && !wb_ready_i, all wb_* outputs hold and no new accept occurs. A simultaneous wb_ready_i and accept is allowed (back-to-back throughput 1/cycle for non-memory instructions).
- Back-pressure from memory: gnt may stay low indefinitely; the request stays asserted and unchanged.

Decomposition:
- Package rv32i_pkg holds:
  - mem_funct3_e: LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2.
  - memstage_state_e: IDLE, REQ, RESP.
- Sub-module mem_align (combinational):
  - store side: lane steering, byte enables, misalign/illegal detect.
  - load side: shift and sign/zero extension.
- memstage holds the FSM and registers only.

Test Plan:
- Reset then non-memory: alu_result=0x0000_1234, rd=5, reg_write=1 -> next cycle wb_valid_o=1, wb_data_o=0x0000_1234, wb_rd_o=5; dmem_req_o never asserted.
- SB at 0x1003, data 0xAABBCCDD, gnt delayed 3 cycles -> dmem_req_o held 4 cycles with addr 0x1000, be 4'b1000, wdata 0xDDDDDDDD; after gnt, wb_valid_o=1, wb_reg_write_o=0.
- LB at 0x2002 with rdata 0x0080_0000 -> wb_data_o=0xFFFF_FF80; LBU at the same address -> 0x0000_0080; LH at 0x2002 with rdata 0x8001_0000 -> 0xFFFF_8001.
- LW at 0x3001 -> no dmem_req_o, exc_misaligned_o=1 for exactly one cycle, wb_reg_write_o=0; load with funct3=3 -> same response.
- Hold wb_ready_i=0 with a result pending -> wb_* stable, ex_ready_o=0; drop rst_i during RESP -> dmem_req_o=0, wb_valid_o=0 next cycle, late rvalid ignored.
- Back-to-back non-memory instructions with wb_ready_i=1 -> one result per cycle, no bubbles.
